// File: rtl/wu_instr_memory.sv
// WU instruction store: run-time loaded parity-protected RAM feeding wud through a
// credit-managed output FIFO, so fetch stalls on buffer occupancy and never on wud ready.
module wu_instr_memory #(
  parameter int ADDR_W       = 10,
  parameter int OPT_PER_INST = 3,
  parameter int OPT_TYPE_W   = 8,
  parameter int OPT_VALUE_W  = 16,
  parameter int OP_W         = 2,
  parameter int CNTL_W       = 2,
  parameter int OBUF_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset_poweron_n,
  input  logic                                ldr__wum__valid,
  input  logic [ADDR_W-1:0]                   ldr__wum__addr,
  input  logic [2*CNTL_W+OP_W+OPT_PER_INST*(OPT_TYPE_W+OPT_VALUE_W)-1:0] ldr__wum__data,
  input  logic                                wuf__wum__read,
  input  logic [ADDR_W-1:0]                   wuf__wum__addr,
  output logic                                wum__wuf__stall,
  output logic                                wum__wud__valid,
  input  logic                                wud__wum__ready,
  output logic [CNTL_W-1:0]                   wum__wud__icntl,
  output logic [CNTL_W-1:0]                   wum__wud__dcntl,
  output logic [OP_W-1:0]                     wum__wud__op,
  output logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type,
  output logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value,
  output logic                                wum__sys__parity_err
);

  localparam int TW    = OPT_PER_INST * OPT_TYPE_W;
  localparam int VW    = OPT_PER_INST * OPT_VALUE_W;
  localparam int W     = 2 * CNTL_W + OP_W + TW + VW;
  localparam int PW    = $clog2(OBUF_DEPTH);
  localparam int CW    = $clog2(OBUF_DEPTH + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  function automatic logic par_bad(input logic [W:0] d);
    return ^d;
  endfunction

  logic [W:0]    mem_r [DEPTH];
  logic [W:0]    ram_q_r;
  logic [W-1:0]  d1_r;
  logic          v0_r;
  logic          v1_r;
  logic          parity_err_r;
  logic [W-1:0]  buf_r [OBUF_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW:0]   pend_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_s;
  logic [W-1:0]  head_s;

  assign valid_s  = (count_r != {CW{1'b0}});
  assign pend_s   = (CW+1)'(count_r) + (CW+1)'(v0_r) + (CW+1)'(v1_r);
  assign wum__wuf__stall = (pend_s >= (CW+1)'(OBUF_DEPTH));
  assign accept_s = wuf__wum__read & ~wum__wuf__stall;
  assign push_s   = v1_r;
  assign pop_s    = valid_s & wud__wum__ready;
  assign head_s   = buf_r[rd_ptr_r];

  // RAM write port and registered read port; the read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (ldr__wum__valid) begin
      mem_r[ldr__wum__addr] <= {even_par(ldr__wum__data), ldr__wum__data};
    end
    if (accept_s) begin
      ram_q_r <= mem_r[wuf__wum__addr];
    end
  end

  // Buffer storage; contents only become visible through count_r, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_r[wr_ptr_r] <= d1_r;
    end
  end

  // Read pipeline, parity check and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      v0_r         <= 1'b0;
      v1_r         <= 1'b0;
      d1_r         <= {W{1'b0}};
      parity_err_r <= 1'b0;
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else begin
      v0_r <= accept_s;
      v1_r <= v0_r;
      if (v0_r) begin
        d1_r <= ram_q_r[W-1:0];
        if (par_bad(ram_q_r)) begin
          parity_err_r <= 1'b1;
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Head-of-buffer fields, forced to zero whenever nothing is valid
  always_comb begin
    wum__wud__valid        = valid_s;
    wum__sys__parity_err   = parity_err_r;
    wum__wud__icntl        = {CNTL_W{1'b0}};
    wum__wud__op           = {OP_W{1'b0}};
    wum__wud__option_type  = {TW{1'b0}};
    wum__wud__option_value = {VW{1'b0}};
    wum__wud__dcntl        = {CNTL_W{1'b0}};
    if (valid_s) begin
      wum__wud__icntl        = head_s[W-1 -: CNTL_W];
      wum__wud__op           = head_s[CNTL_W+VW+TW +: OP_W];
      wum__wud__option_type  = head_s[CNTL_W+VW +: TW];
      wum__wud__option_value = head_s[CNTL_W +: VW];
      wum__wud__dcntl        = head_s[CNTL_W-1:0];
    end else begin
      wum__wud__icntl        = {CNTL_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_wu_instr_memory.sv
// Self-checking bench for wu_instr_memory: vector table for load/read latency, scoreboard
// queue for every delivered word, hand sequences for backpressure, collisions, parity, reset.
module tb_wu_instr_memory;
  localparam int ADDR_W = 10;
  localparam int W      = 78;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ldr_valid;
  logic [ADDR_W-1:0] ldr_addr;
  logic [W-1:0]      ldr_data;
  logic              rd;
  logic [ADDR_W-1:0] raddr;
  logic              stall, valid, ready, perr;
  logic [1:0]        icntl, dcntl, op;
  logic [23:0]       otype;
  logic [47:0]       ovalue;
  logic [W-1:0]      got;

  assign got = {icntl, op, otype, ovalue, dcntl};

  wu_instr_memory dut (
    .clk(clk), .reset_poweron_n(rst_n),
    .ldr__wum__valid(ldr_valid), .ldr__wum__addr(ldr_addr), .ldr__wum__data(ldr_data),
    .wuf__wum__read(rd), .wuf__wum__addr(raddr), .wum__wuf__stall(stall),
    .wum__wud__valid(valid), .wud__wum__ready(ready),
    .wum__wud__icntl(icntl), .wum__wud__dcntl(dcntl), .wum__wud__op(op),
    .wum__wud__option_type(otype), .wum__wud__option_value(ovalue),
    .wum__sys__parity_err(perr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] model_mem [0:(1<<ADDR_W)-1];
  logic [W-1:0] exp_q [$];
  logic overflow = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] ic, input logic [1:0] o,
                                      input logic [23:0] t, input logic [47:0] v,
                                      input logic [1:0] dc);
    return {ic, o, t, v, dc};
  endfunction

  // Scoreboard: sampled mid-cycle, mirrors what happens at the following rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got %h expected no word", got);
        end else begin
          check("sb_word", got, exp_q.pop_front());
        end
      end
      if (rd && !stall) exp_q.push_back(model_mem[raddr]);
      if (dut.v1_r && int'(dut.count_r) == DEPTH) overflow = 1'b1;
    end
    if (ldr_valid) model_mem[ldr_addr] = ldr_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    ldr_valid = 1'b1; ldr_addr = a; ldr_data = d;
    tick();
    ldr_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    ready = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || valid) && c < 40) begin
      tick();
      c++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    ready = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ic;
    logic [1:0]        o;
    logic [23:0]       t;
    logic [47:0]       v;
    logic [1:0]        dc;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int acc, first_stall, vcnt;
    logic st;
    logic [W:0] tmp;

    tbl[0] = '{10'd5,    2'd1, 2'd2, 24'h000011, 48'h00000000ABCD, 2'd3};
    tbl[1] = '{10'd0,    2'd0, 2'd0, 24'h000000, 48'h000000000000, 2'd0};
    tbl[2] = '{10'd1023, 2'd3, 2'd3, 24'hFFFFFF, 48'hFFFFFFFFFFFF, 2'd3};
    tbl[3] = '{10'd100,  2'd2, 2'd1, 24'hA55A0F, 48'h123456789ABC, 2'd1};
    tbl[4] = '{10'd513,  2'd1, 2'd3, 24'h807F01, 48'h8000FFFF0001, 2'd2};

    rst_n = 1'b0; ldr_valid = 1'b0; ldr_addr = '0; ldr_data = '0;
    rd = 1'b0; raddr = '0; ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", W'(valid), W'(0));
    check("rst_stall", W'(stall), W'(0));
    check("rst_perr", W'(perr), W'(0));
    check("rst_data", got, W'(0));
    rst_n = 1'b1;

    // Table: load, read once, check 2-clock latency and fields, then pop
    foreach (tbl[i]) load(tbl[i].addr, mk(tbl[i].ic, tbl[i].o, tbl[i].t, tbl[i].v, tbl[i].dc));
    foreach (tbl[i]) begin
      rd = 1'b1; raddr = tbl[i].addr;
      tick();
      rd = 1'b0;
      check("lat_e0_valid", W'(valid), W'(0));
      tick();
      check("lat_e1_valid", W'(valid), W'(0));
      tick();
      check("lat_e2_valid", W'(valid), W'(1));
      check("f_icntl", W'(icntl), W'(tbl[i].ic));
      check("f_op", W'(op), W'(tbl[i].o));
      check("f_type", W'(otype), W'(tbl[i].t));
      check("f_value", W'(ovalue), W'(tbl[i].v));
      check("f_dcntl", W'(dcntl), W'(tbl[i].dc));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("pop_valid_fall", W'(valid), W'(0));
    end

    // Backpressure: ready low, stream addrs 0..7
    for (int i = 0; i < 8; i++) load(ADDR_W'(i), mk(2'(i), 2'(i + 1), 24'(i * 7919), 48'(i * 104729 + 3), 2'(~i)));
    rd = 1'b1; acc = 0; first_stall = -1;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      if (stall && first_stall < 0) first_stall = acc;
      if (c == 10) begin
        check("buf_full_count", W'(dut.count_r), W'(DEPTH));
        check("stall_held", W'(stall), W'(1));
        ready = 1'b1;
      end
      raddr = ADDR_W'(acc);
      st = stall;
      tick();
      if (!st) acc++;
    end
    rd = 1'b0;
    check("stall_after_4", W'(first_stall), W'(4));
    check("all_8_accepted", W'(acc), W'(8));
    drain();

    // Back-to-back with ready held high: one read per clock, never stalled
    ready = 1'b1; rd = 1'b1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      raddr = ADDR_W'(7 - c);
      if (!stall) acc++;
      tick();
    end
    rd = 1'b0;
    check("b2b_no_stall", W'(acc), W'(8));
    drain();

    // Same-cycle write/read: old word first, new word on the following read
    load(10'd9, mk(2'd2, 2'd1, 24'h0BAD01, 48'h0000CAFE0000, 2'd1));
    ldr_valid = 1'b1; ldr_addr = 10'd9; ldr_data = mk(2'd1, 2'd3, 24'h5EED00, 48'h00000000F00D, 2'd2);
    rd = 1'b1; raddr = 10'd9;
    tick();
    ldr_valid = 1'b0;
    tick();
    rd = 1'b0;
    repeat (3) tick();
    check("collide_old", got, mk(2'd2, 2'd1, 24'h0BAD01, 48'h0000CAFE0000, 2'd1));
    ready = 1'b1;
    tick();
    check("collide_new", got, mk(2'd1, 2'd3, 24'h5EED00, 48'h00000000F00D, 2'd2));
    tick();
    ready = 1'b0;
    check("collide_empty", W'(valid), W'(0));

    // Parity: corrupt stored parity of addr 2, word still delivered, flag sticky
    tmp = dut.mem_r[2];
    tmp[W] = ~tmp[W];
    dut.mem_r[2] = tmp;
    rd = 1'b1; raddr = 10'd2;
    tick();
    rd = 1'b0;
    check("perr_e0", W'(perr), W'(0));
    tick();
    check("perr_e1", W'(perr), W'(1));
    tick();
    check("perr_word", got, model_mem[2]);
    drain();
    rd = 1'b1; raddr = 10'd5;
    tick();
    rd = 1'b0;
    drain();
    check("perr_sticky", W'(perr), W'(1));

    // Reset with the pipeline and buffer loaded
    rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      raddr = ADDR_W'(k);
      tick();
    end
    rd = 1'b0;
    check("pre_reset_stall", W'(stall), W'(1));
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", W'(valid), W'(0));
    check("mid_rst_stall", W'(stall), W'(0));
    check("mid_rst_perr", W'(perr), W'(0));
    check("mid_rst_data", got, W'(0));
    rst_n = 1'b1; ready = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid) vcnt++;
    end
    check("no_stale_after_rst", W'(vcnt), W'(0));
    ready = 1'b0;

    check("no_overflow", W'(overflow), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
